// File: rtl/pool_writeback_if.sv
// Word-addressed memory write-request bus used by pool_writeback.
// master: drives mem_req_valid/mem_addr/mem_wdata/mem_be; slave: drives mem_req_ready.
interface pool_writeback_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;

  modport master (
    output mem_req_valid, mem_addr, mem_wdata, mem_be,
    input  mem_req_ready
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_wdata, mem_be,
    output mem_req_ready
  );
endinterface

// File: rtl/pool_writeback.sv
// Pooled-sample writeback: bounds-checks (row,col) samples, queues byte writes
// in a small FIFO and issues them as single-lane word writes on the mem bus.
// Ports: clk, reset (sync, active-low), cfg_* layer setup, in_* sample stream
// (no ready), mem (request bus), busy/done status, sticky errors, wr_count.
module pool_writeback #(
  parameter int MAX_N      = 512,
  parameter int N_BITS     = $clog2(MAX_N + 1),
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_start,
  input  logic [N_BITS-1:0]     cfg_out_h,
  input  logic [N_BITS-1:0]     cfg_out_w,
  input  logic [ADDR_W+1:0]     cfg_base_byte,
  input  logic                  in_valid,
  input  logic [N_BITS-1:0]     in_row,
  input  logic [N_BITS-1:0]     in_col,
  input  logic [7:0]            in_data,
  pool_writeback_if.master      mem,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow_err,
  output logic                  oob_err,
  output logic                  stray_err,
  output logic [2*N_BITS-1:0]   wr_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = ADDR_W + 2;
  localparam int MW = 2 * N_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] word;
    logic [1:0]        lane;
    logic [7:0]        data;
  } ent_t;

  state_t            state;
  logic [N_BITS-1:0] h_q;
  logic [N_BITS-1:0] w_q;
  logic [BW-1:0]     base_q;
  logic [MW-1:0]     total_q;

  ent_t              fifo [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     occ;

  logic              in_run;
  logic              inb;
  logic              full;
  logic              push;
  logic              pop;
  logic              oob_hit;
  logic              ovf_hit;
  logic              stray_hit;
  logic [BW-1:0]     byte_a;
  logic [MW-1:0]     wr_cnt_nxt;
  logic [PW-1:0]     rd_ptr_n;
  logic [CW-1:0]     occ_n;
  ent_t              new_ent;
  ent_t              head_ent;

  assign in_run    = state == S_RUN;
  assign inb       = (in_row < h_q) && (in_col < w_q);
  assign full      = occ == CW'(FIFO_DEPTH);
  assign push      = in_valid && in_run && inb && !full;
  assign pop       = mem.mem_req_valid && mem.mem_req_ready;
  assign oob_hit   = in_valid && in_run && !inb;
  assign ovf_hit   = in_valid && in_run && inb && full;
  assign stray_hit = in_valid && !in_run;

  // Modular byte address; the product is truncated before the adds.
  assign byte_a = base_q
                + BW'(MW'(in_row) * MW'(w_q))
                + BW'(in_col);

  assign new_ent = '{
    word: byte_a[BW-1:2],
    lane: byte_a[1:0],
    data: in_data
  };

  assign wr_cnt_nxt = wr_count + MW'(push);
  assign rd_ptr_n   = rd_ptr + PW'(pop);
  assign occ_n      = occ + CW'(push) - CW'(pop);

  // When nothing older survives this cycle, the next head is the
  // sample being pushed right now, so bypass the storage array.
  assign head_ent = (occ == CW'(pop)) ? new_ent : fifo[rd_ptr_n];

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= new_ent;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      occ               <= '0;
      mem.mem_req_valid <= 1'b0;
      mem.mem_addr      <= '0;
      mem.mem_be        <= '0;
      mem.mem_wdata     <= '0;
    end else begin
      rd_ptr            <= rd_ptr_n;
      wr_ptr            <= wr_ptr + PW'(push);
      occ               <= occ_n;
      mem.mem_req_valid <= occ_n != '0;
      if (occ_n != '0) begin
        mem.mem_addr  <= head_ent.word;
        mem.mem_be    <= 4'b0001 << head_ent.lane;
        mem.mem_wdata <= {4{head_ent.data}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow_err <= 1'b0;
      oob_err      <= 1'b0;
      stray_err    <= 1'b0;
      wr_count     <= '0;
      h_q          <= '0;
      w_q          <= '0;
      base_q       <= '0;
      total_q      <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cfg_start) begin
            h_q          <= cfg_out_h;
            w_q          <= cfg_out_w;
            base_q       <= cfg_base_byte;
            total_q      <= MW'(cfg_out_h) * MW'(cfg_out_w);
            wr_count     <= '0;
            overflow_err <= 1'b0;
            oob_err      <= 1'b0;
            stray_err    <= 1'b0;
            busy         <= 1'b1;
            state        <= S_RUN;
          end
        end
        S_RUN: begin
          wr_count <= wr_cnt_nxt;
          if (wr_cnt_nxt == total_q) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (occ == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // Placed after the clear so a same-cycle hit still latches.
      if (stray_hit) stray_err    <= 1'b1;
      if (oob_hit)   oob_err      <= 1'b1;
      if (ovf_hit)   overflow_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pool_writeback.sv
// Self-checking bench for pool_writeback against a queue-based layer model.
// Directed scenarios plus randomized layers with random memory backpressure.
module tb_pool_writeback;
  localparam int NB    = 10;
  localparam int AW    = 16;
  localparam int BW    = 18;
  localparam int DEPTH = 8;

  typedef logic [51:0] wr_t;
  typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mst_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_start = 1'b0;
  logic [NB-1:0] cfg_out_h = '0;
  logic [NB-1:0] cfg_out_w = '0;
  logic [BW-1:0] cfg_base_byte = '0;
  logic          in_valid = 1'b0;
  logic [NB-1:0] in_row = '0;
  logic [NB-1:0] in_col = '0;
  logic [7:0]    in_data = '0;
  logic          rdy = 1'b0;
  logic          busy;
  logic          done;
  logic          overflow_err;
  logic          oob_err;
  logic          stray_err;
  logic [2*NB-1:0] wr_count;

  pool_writeback_if #(.ADDR_W(AW)) mem ();
  assign mem.mem_req_ready = rdy;

  pool_writeback #(
    .MAX_N(512), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start),
    .cfg_out_h(cfg_out_h), .cfg_out_w(cfg_out_w),
    .cfg_base_byte(cfg_base_byte), .in_valid(in_valid),
    .in_row(in_row), .in_col(in_col), .in_data(in_data),
    .mem(mem.master), .busy(busy), .done(done),
    .overflow_err(overflow_err), .oob_err(oob_err),
    .stray_err(stray_err), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model state
  mst_t m_st = M_IDLE;
  int   m_h, m_w, m_base, m_total, m_cnt;
  bit   m_ovf, m_oob, m_stray;
  int   m_done;
  wr_t  m_fifo[$];
  wr_t  exp_q[$];
  wr_t  act_q[$];
  int   dut_done;
  int   dut_vcycles;

  always @(negedge clk) begin
    if (mem.mem_req_valid && mem.mem_req_ready)
      act_q.push_back({mem.mem_addr, mem.mem_be, mem.mem_wdata});
    if (done) dut_done++;
    if (mem.mem_req_valid) dut_vcycles++;
  end

  function automatic wr_t ent(input int r, input int c, input logic [7:0] d);
    longint b;
    b = (longint'(m_base) + longint'(r) * m_w + c) % (longint'(1) << 18);
    return {16'(b >> 2), 4'(1 << (b % 4)), {4{d}}};
  endfunction

  task automatic clear();
    exp_q.delete();
    act_q.delete();
    m_done = 0;
    dut_done = 0;
    dut_vcycles = 0;
  endtask

  // One clock: drive inputs, advance the model, step past the edge.
  task automatic cycle(input bit v, input int r, input int c,
                       input logic [7:0] d, input bit st,
                       input int h, input int w, input int base);
    int occ0;
    bit run;
    in_valid = v; in_row = NB'(r); in_col = NB'(c); in_data = d;
    cfg_start = st; cfg_out_h = NB'(h); cfg_out_w = NB'(w);
    cfg_base_byte = BW'(base);
    if (!reset) begin
      m_st = M_IDLE; m_fifo.delete(); m_cnt = 0;
      m_ovf = 0; m_oob = 0; m_stray = 0;
    end else begin
      occ0 = m_fifo.size();
      run = (m_st == M_RUN);
      if (rdy && occ0 > 0) exp_q.push_back(m_fifo.pop_front());
      case (m_st)
        M_IDLE: if (st) begin
          m_h = h; m_w = w; m_base = base; m_total = h * w;
          m_cnt = 0; m_ovf = 0; m_oob = 0; m_stray = 0;
          m_st = M_RUN;
        end
        M_DRAIN: if (occ0 == 0) begin m_st = M_DONE; m_done++; end
        M_DONE: m_st = M_IDLE;
        default: ;
      endcase
      if (v && !run) m_stray = 1;
      if (v && run) begin
        if (r >= m_h || c >= m_w) m_oob = 1;
        else if (occ0 >= DEPTH) m_ovf = 1;
        else begin m_fifo.push_back(ent(r, c, d)); m_cnt++; end
      end
      if (run && m_cnt == m_total) m_st = M_DRAIN;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 8'h00, 0, 0, 0, 0);
  endtask

  task automatic finish_layer(input int budget, output bit ok);
    int n;
    n = 0;
    while (m_st != M_IDLE && n < budget) begin
      cycle(0, 0, 0, 8'h00, 0, 0, 0, 0);
      n++;
    end
    ok = (m_st == M_IDLE);
  endtask

  task automatic test_reset();
    reset = 0; rdy = 0;
    idle(2);
    checks++; if (mem.mem_req_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", mem.mem_req_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else passed++;
    checks++; if ({overflow_err, oob_err, stray_err} !== 3'b000)
      $display("FAIL rst_errs got %b want 000", {overflow_err, oob_err, stray_err}); else passed++;
    checks++; if (wr_count !== '0) $display("FAIL rst_wr_count got %0d want 0", wr_count); else passed++;
    checks++; if ({mem.mem_addr, mem.mem_be, mem.mem_wdata} !== 52'h0)
      $display("FAIL rst_bus got %h want 0", {mem.mem_addr, mem.mem_be, mem.mem_wdata}); else passed++;
    reset = 1;
    idle(1);
  endtask

  task automatic test_basic();
    wr_t gold[4];
    bit ok;
    gold[0] = {16'h0040, 4'b0001, 32'h05050505};
    gold[1] = {16'h0040, 4'b0010, 32'hFDFDFDFD};
    gold[2] = {16'h0040, 4'b0100, 32'h07070707};
    gold[3] = {16'h0040, 4'b1000, 32'h01010101};
    clear(); rdy = 1;
    cycle(0, 0, 0, 8'h00, 1, 2, 2, 'h100);
    cycle(1, 0, 0, 8'h05, 0, 0, 0, 0);
    checks++; if (mem.mem_req_valid !== 1'b1 || mem.mem_addr !== 16'h0040)
      $display("FAIL basic_latency got v=%b a=%h want v=1 a=0040", mem.mem_req_valid, mem.mem_addr); else passed++;
    cycle(1, 0, 1, 8'hFD, 0, 0, 0, 0);
    cycle(1, 1, 0, 8'h07, 0, 0, 0, 0);
    cycle(1, 1, 1, 8'h01, 0, 0, 0, 0);
    finish_layer(20, ok);
    checks++; if (!ok) $display("FAIL basic_timeout got busy want idle"); else passed++;
    checks++; if (act_q.size() !== 4) $display("FAIL basic_nwr got %0d want 4", act_q.size()); else passed++;
    for (int i = 0; i < 4 && i < act_q.size(); i++) begin
      checks++; if (act_q[i] !== gold[i]) $display("FAIL basic_wr%0d got %h want %h", i, act_q[i], gold[i]); else passed++;
    end
    checks++; if (dut_done !== 1) $display("FAIL basic_done got %0d want 1", dut_done); else passed++;
    checks++; if ({overflow_err, oob_err, stray_err} !== 3'b000)
      $display("FAIL basic_errs got %b want 000", {overflow_err, oob_err, stray_err}); else passed++;
    checks++; if (wr_count !== 20'd4) $display("FAIL basic_wr_count got %0d want 4", wr_count); else passed++;
  endtask

  task automatic test_backpressure();
    int base;
    clear(); rdy = 0;
    base = int'($urandom_range(0, (1 << 18) - 1));
    cycle(0, 0, 0, 8'h00, 1, 4, 4, base);
    for (int i = 0; i < 9; i++) cycle(1, i / 4, i % 4, 8'($urandom), 0, 0, 0, 0);
    idle(1);
    checks++; if (overflow_err !== 1'b1) $display("FAIL bp_overflow got %b want 1", overflow_err); else passed++;
    checks++; if (wr_count !== 20'd8) $display("FAIL bp_wr_count got %0d want 8", wr_count); else passed++;
    checks++; if (mem.mem_req_valid !== 1'b1 || {mem.mem_addr, mem.mem_be, mem.mem_wdata} !== m_fifo[0])
      $display("FAIL bp_hold got %h want %h", {mem.mem_addr, mem.mem_be, mem.mem_wdata}, m_fifo[0]); else passed++;
    rdy = 1;
    idle(12);
    checks++; if (act_q.size() !== 8 || exp_q.size() !== 8)
      $display("FAIL bp_nwr got %0d want 8", act_q.size()); else passed++;
    for (int i = 0; i < 8 && i < act_q.size() && i < exp_q.size(); i++) begin
      checks++; if (act_q[i] !== exp_q[i]) $display("FAIL bp_wr%0d got %h want %h", i, act_q[i], exp_q[i]); else passed++;
    end
    checks++; if (dut_done !== 0 || busy !== 1'b1)
      $display("FAIL bp_nodone got done=%0d busy=%b want 0 1", dut_done, busy); else passed++;
    reset = 0; idle(1); reset = 1; idle(1);
  endtask

  task automatic test_oob();
    bit ok;
    clear(); rdy = 1;
    cycle(0, 0, 0, 8'h00, 1, 2, 2, int'($urandom_range(0, 4095)));
    cycle(1, 2, 0, 8'h33, 0, 0, 0, 0);
    checks++; if (oob_err !== 1'b1) $display("FAIL oob_flag got %b want 1", oob_err); else passed++;
    checks++; if (wr_count !== 20'd0) $display("FAIL oob_wr_count got %0d want 0", wr_count); else passed++;
    cycle(1, 0, 2, 8'h44, 0, 0, 0, 0);
    idle(2);
    checks++; if (dut_vcycles !== 0) $display("FAIL oob_nowrite got %0d want 0", dut_vcycles); else passed++;
    for (int i = 0; i < 4; i++) cycle(1, i / 2, i % 2, 8'($urandom), 0, 0, 0, 0);
    finish_layer(20, ok);
    checks++; if (!ok) $display("FAIL oob_timeout got busy want idle"); else passed++;
    checks++; if (act_q.size() !== exp_q.size() || act_q.size() !== 4)
      $display("FAIL oob_nwr got %0d want 4", act_q.size()); else passed++;
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      checks++; if (act_q[i] !== exp_q[i]) $display("FAIL oob_wr%0d got %h want %h", i, act_q[i], exp_q[i]); else passed++;
    end
    checks++; if (oob_err !== 1'b1 || dut_done !== 1)
      $display("FAIL oob_sticky got oob=%b done=%0d want 1 1", oob_err, dut_done); else passed++;
  endtask

  task automatic test_stray_start();
    bit ok;
    clear(); rdy = 1;
    cycle(1, 0, 0, 8'h11, 0, 0, 0, 0);
    idle(2);
    checks++; if (stray_err !== 1'b1) $display("FAIL stray_flag got %b want 1", stray_err); else passed++;
    checks++; if (act_q.size() !== 0) $display("FAIL stray_nowrite got %0d want 0", act_q.size()); else passed++;
    cycle(0, 0, 0, 8'h00, 1, 1, 3, 'h2001);
    checks++; if (stray_err !== 1'b0) $display("FAIL stray_clear got %b want 0", stray_err); else passed++;
    cycle(1, 0, 0, 8'h21, 0, 0, 0, 0);
    cycle(1, 0, 1, 8'h22, 1, 5, 5, 'h3000);
    cycle(1, 0, 2, 8'h23, 0, 0, 0, 0);
    finish_layer(20, ok);
    checks++; if (!ok || dut_done !== 1)
      $display("FAIL ign_start_done got %0d want 1", dut_done); else passed++;
    checks++; if (wr_count !== 20'd3) $display("FAIL ign_start_count got %0d want 3", wr_count); else passed++;
    checks++; if (act_q.size() !== exp_q.size() || act_q.size() !== 3)
      $display("FAIL ign_start_nwr got %0d want 3", act_q.size()); else passed++;
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      checks++; if (act_q[i] !== exp_q[i]) $display("FAIL ign_start_wr%0d got %h want %h", i, act_q[i], exp_q[i]); else passed++;
    end
  endtask

  task automatic test_zero();
    clear(); rdy = 1;
    cycle(0, 0, 0, 8'h00, 1, 0, 5, 'h40);
    for (int k = 0; k < 5; k++) begin
      idle(1);
      checks++; if (done !== (m_st == M_DONE))
        $display("FAIL zero_done_c%0d got %b want %b", k, done, m_st == M_DONE); else passed++;
    end
    checks++; if (dut_vcycles !== 0 || dut_done !== 1)
      $display("FAIL zero_summary got v=%0d done=%0d want 0 1", dut_vcycles, dut_done); else passed++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear(); rdy = 1;
    cycle(0, 0, 0, 8'h00, 1, 1, 8, int'($urandom_range(0, 65535)));
    for (int i = 0; i < 8; i++) cycle(1, 0, i, 8'($urandom), 0, 0, 0, 0);
    idle(1);
    checks++; if (act_q.size() !== 8 || dut_vcycles !== 8)
      $display("FAIL b2b_rate got wr=%0d vcyc=%0d want 8 8", act_q.size(), dut_vcycles); else passed++;
    finish_layer(20, ok);
    checks++; if (!ok || act_q.size() !== exp_q.size())
      $display("FAIL b2b_nwr got %0d want %0d", act_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      checks++; if (act_q[i] !== exp_q[i]) $display("FAIL b2b_wr%0d got %h want %h", i, act_q[i], exp_q[i]); else passed++;
    end
  endtask

  task automatic test_random();
    int h, w, base, n;
    for (int l = 0; l < 6; l++) begin
      clear(); rdy = 1;
      h = int'($urandom_range(1, 4));
      w = int'($urandom_range(1, 4));
      base = (l == 0) ? (1 << 18) - 3 : int'($urandom_range(0, (1 << 18) - 1));
      cycle(0, 0, 0, 8'h00, 1, h, w, base);
      n = 0;
      while (m_st != M_IDLE && n < 300) begin
        rdy = ($urandom % 4) != 0;
        cycle(($urandom % 3) != 0, int'($urandom_range(0, h)),
              int'($urandom_range(0, w)), 8'($urandom), 0, 0, 0, 0);
        n++;
      end
      rdy = 1;
      checks++; if (m_st != M_IDLE) $display("FAIL rnd%0d_timeout got busy want idle", l); else passed++;
      checks++; if (act_q.size() !== exp_q.size())
        $display("FAIL rnd%0d_nwr got %0d want %0d", l, act_q.size(), exp_q.size()); else passed++;
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
        checks++; if (act_q[i] !== exp_q[i]) $display("FAIL rnd%0d_wr%0d got %h want %h", l, i, act_q[i], exp_q[i]); else passed++;
      end
      checks++; if ({overflow_err, oob_err, stray_err} !== {m_ovf, m_oob, m_stray})
        $display("FAIL rnd%0d_errs got %b want %b", l, {overflow_err, oob_err, stray_err}, {m_ovf, m_oob, m_stray}); else passed++;
      checks++; if (wr_count !== 20'(m_cnt)) $display("FAIL rnd%0d_wr_count got %0d want %0d", l, wr_count, m_cnt); else passed++;
      checks++; if (dut_done !== m_done) $display("FAIL rnd%0d_done got %0d want %0d", l, dut_done, m_done); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    clear(); rdy = 0;
    cycle(0, 0, 0, 8'h00, 1, 4, 4, 'h500);
    for (int i = 0; i < 3; i++) cycle(1, 0, i, 8'($urandom), 0, 0, 0, 0);
    checks++; if (mem.mem_req_valid !== 1'b1) $display("FAIL rmid_pre got %b want 1", mem.mem_req_valid); else passed++;
    reset = 0;
    idle(1);
    checks++; if (mem.mem_req_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rmid_post got v=%b busy=%b want 0 0", mem.mem_req_valid, busy); else passed++;
    reset = 1; rdy = 1;
    idle(10);
    checks++; if (act_q.size() !== 0) $display("FAIL rmid_nowrite got %0d want 0", act_q.size()); else passed++;
    cycle(1, 0, 0, 8'h55, 0, 0, 0, 0);
    idle(2);
    checks++; if (stray_err !== 1'b1 || act_q.size() !== 0)
      $display("FAIL rmid_needs_start got stray=%b wr=%0d want 1 0", stray_err, act_q.size()); else passed++;
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_oob();
    test_stray_start();
    test_zero();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
